// File: rtl/sc_line_buf_2d_pkg.sv
// Shared widths for the stencil line buffer: element width, taps per column, column width.
// Also provides the row/column counter width helper.
package sc_line_buf_2d_pkg;
    localparam int BW   = 32;
    localparam int ST   = 3;
    localparam int COLW = ST * BW;

    function automatic int cnt_w(input int w, input int h);
        int m;
        m = (w > h) ? w : h;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/sc_row_fifo.sv
// One row of history: W-deep circular buffer, read-before-write, output is the element pushed W pushes ago.
// Output is combinational from the read pointer; state only advances on i_push.
module sc_row_fifo
    import sc_line_buf_2d_pkg::*;
#(
    parameter int W  = 16,
    parameter int DW = BW
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_dout
);
    localparam int PW = (W <= 2) ? 1 : $clog2(W);

    logic [DW-1:0] r_mem [W];
    logic [PW-1:0] r_ptr;

    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_push) begin
            r_ptr <= (r_ptr == PW'(W - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    // Contents need no reset: nothing reaches the output until ST-1 full rows are rewritten.
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem[r_ptr] <= i_din;
        end
    end
endmodule

// File: rtl/sc_line_buf_2d.sv
// Raster stream to vertical ST-element columns for the stencil core; 1-cycle latency, push-only downstream.
// Stalls (i_pix_vld=0) freeze all state; the core cannot backpressure.
module sc_line_buf_2d
    import sc_line_buf_2d_pkg::*;
#(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_sof,
    input  logic            i_pix_vld,
    input  logic [BW-1:0]   i_pix,
    input  logic            i_wt_we,
    input  logic [COLW-1:0] i_wt_data,
    output logic            o_col_vld,
    output logic [COLW-1:0] o_col,
    output logic [COLW-1:0] o_col_wt,
    output logic            o_eof
);
    localparam int CW = cnt_w(W, H);

    logic [CW-1:0]   r_c_cnt;
    logic [CW-1:0]   r_r_cnt;
    logic            r_col_vld;
    logic [COLW-1:0] r_col;
    logic [COLW-1:0] r_col_wt;
    logic            r_eof;

    logic [CW-1:0]   w_c_eff;
    logic [CW-1:0]   w_r_eff;
    logic [CW-1:0]   w_c_nxt;
    logic [CW-1:0]   w_r_nxt;
    logic            w_out_ok;
    logic            w_last;
    logic [BW-1:0]   w_fifo_in  [ST-1];
    logic [BW-1:0]   w_fifo_out [ST-1];
    logic [COLW-1:0] w_col;

    // Cascade: FIFO k holds row r-1-k; the current pixel forms the top slice.
    for (genvar k = 0; k < ST - 1; k++) begin : g_rows
        if (k == 0) begin : g_head
            assign w_fifo_in[k] = i_pix;
        end else begin : g_tail
            assign w_fifo_in[k] = w_fifo_out[k-1];
        end

        sc_row_fifo #(.W(W), .DW(BW)) u_row (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_push  (i_pix_vld),
            .i_din   (w_fifo_in[k]),
            .o_dout  (w_fifo_out[k])
        );

        assign w_col[k*BW +: BW] = w_fifo_out[ST-2-k];
    end
    assign w_col[(ST-1)*BW +: BW] = i_pix;

    always_comb begin
        w_c_eff  = i_sof ? '0 : r_c_cnt;
        w_r_eff  = i_sof ? '0 : r_r_cnt;
        w_c_nxt  = w_c_eff + 1'b1;
        w_r_nxt  = w_r_eff;
        if (w_c_eff == CW'(W - 1)) begin
            w_c_nxt = '0;
            w_r_nxt = (w_r_eff == CW'(H - 1)) ? '0 : w_r_eff + 1'b1;
        end
        w_out_ok = (w_r_eff >= CW'(ST - 1));
        w_last   = (w_r_eff == CW'(H - 1)) && (w_c_eff == CW'(W - 1));
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_c_cnt   <= '0;
            r_r_cnt   <= '0;
            r_col_vld <= 1'b0;
            r_col     <= '0;
            r_col_wt  <= '0;
            r_eof     <= 1'b0;
        end else begin
            if (i_wt_we) begin
                r_col_wt <= i_wt_data;
            end
            r_col_vld <= 1'b0;
            r_eof     <= 1'b0;
            if (i_pix_vld) begin
                r_c_cnt <= w_c_nxt;
                r_r_cnt <= w_r_nxt;
                if (w_out_ok) begin
                    r_col_vld <= 1'b1;
                    r_col     <= w_col;
                    r_eof     <= w_last;
                end else if (i_sof) begin
                    // A restarted frame looks like a reset to the core, weights aside.
                    r_col <= '0;
                end
            end
        end
    end

    assign o_col_vld = r_col_vld;
    assign o_col     = r_col;
    assign o_col_wt  = r_col_wt;
    assign o_eof     = r_eof;
endmodule

// File: tb/tb_sc_line_buf_2d.sv
// Directed bench for sc_line_buf_2d at W=4, H=4; element value = row*16+col.
module tb_sc_line_buf_2d;
    import sc_line_buf_2d_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            t_sof;
    logic            t_vld;
    logic [BW-1:0]   t_pix;
    logic            t_we;
    logic [COLW-1:0] t_wdat;
    logic            o_col_vld;
    logic [COLW-1:0] o_col;
    logic [COLW-1:0] o_col_wt;
    logic            o_eof;

    int              n_tests = 0;
    int              n_fail  = 0;
    int              n_vld;
    logic [COLW-1:0] exp_wt;

    sc_line_buf_2d #(.W(W), .H(H)) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_sof     (t_sof),
        .i_pix_vld (t_vld),
        .i_pix     (t_pix),
        .i_wt_we   (t_we),
        .i_wt_data (t_wdat),
        .o_col_vld (o_col_vld),
        .o_col     (o_col),
        .o_col_wt  (o_col_wt),
        .o_eof     (o_eof)
    );

    always #5 clk = ~clk;

    function automatic logic [COLW-1:0] exp_col(input int r, input int c);
        return {32'(r * 16 + c), 32'((r - 1) * 16 + c), 32'((r - 2) * 16 + c)};
    endfunction

    task automatic chk(input string tag, input logic [COLW-1:0] obs, input logic [COLW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vld, input logic sof, input logic [BW-1:0] pix, input logic we);
        @(negedge clk);
        t_vld = vld;
        t_sof = sof;
        t_pix = pix;
        t_we  = we;
        @(posedge clk);
        #1;
        t_we  = 1'b0;
        if (o_col_vld) n_vld++;
    endtask

    // Streams raster elements [first, last) of one frame and checks every output after each edge.
    task automatic stream(input logic use_sof, input logic toggle, input int wt_at,
                          input int first, input int last);
        int r;
        int c;
        for (int i = first; i < last; i++) begin
            r = i / W;
            c = i % W;
            step(1'b1, use_sof && (i == first), BW'(r * 16 + c), i == wt_at);
            if (i == wt_at) exp_wt = t_wdat;
            chk("col_vld", COLW'(o_col_vld), COLW'(r >= 2));
            if (r >= 2) chk("col", o_col, exp_col(r, c));
            chk("eof", COLW'(o_eof), COLW'(r == H - 1 && c == W - 1));
            chk("col_wt", o_col_wt, exp_wt);
            if (toggle) begin
                step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
                chk("idle_vld", COLW'(o_col_vld), '0);
                chk("idle_eof", COLW'(o_eof), '0);
                if (r >= 2) chk("idle_col_hold", o_col, exp_col(r, c));
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        t_sof  = 1'b0;
        t_vld  = 1'b0;
        t_pix  = '0;
        t_we   = 1'b0;
        t_wdat = '0;
        exp_wt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col_vld", COLW'(o_col_vld), '0);
        chk("rst_col", o_col, '0);
        chk("rst_col_wt", o_col_wt, '0);
        chk("rst_eof", COLW'(o_eof), '0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame; first column appears one cycle after 0x20 enters.
        n_vld = 0;
        stream(1'b1, 1'b0, -1, 0, 8);
        step(1'b1, 1'b0, 32'h20, 1'b0);
        chk("t1_first_vld", COLW'(o_col_vld), COLW'(1));
        chk("t1_first_col", o_col, 96'h00000020_00000010_00000000);
        stream(1'b0, 1'b0, -1, 9, 16);
        chk("t1_count", COLW'(n_vld), COLW'(8));

        // Same frame with a bubble after every element.
        n_vld = 0;
        stream(1'b1, 1'b1, -1, 0, 16);
        chk("t2_count", COLW'(n_vld), COLW'(8));

        // Back-to-back frame relying on counter wrap, no sof.
        n_vld = 0;
        stream(1'b0, 1'b0, -1, 0, 16);
        chk("t3_count", COLW'(n_vld), COLW'(8));
        chk("t3_last_col", o_col, 96'h00000033_00000023_00000013);
        chk("t3_eof", COLW'(o_eof), COLW'(1));

        // Abandon a frame in row 2, restart with sof.
        stream(1'b1, 1'b0, -1, 0, 10);
        n_vld = 0;
        stream(1'b1, 1'b0, -1, 0, 16);
        chk("t4_count", COLW'(n_vld), COLW'(8));

        // Weight load while streaming, then held through another frame.
        t_wdat = 96'h0000000A_0000000B_0000000C;
        n_vld  = 0;
        stream(1'b1, 1'b0, 5, 0, 16);
        chk("t5_count", COLW'(n_vld), COLW'(8));
        n_vld = 0;
        stream(1'b0, 1'b0, -1, 0, 16);
        chk("t5_wt_held", o_col_wt, 96'h0000000A_0000000B_0000000C);
        chk("t5_count2", COLW'(n_vld), COLW'(8));

        // Asynchronous reset between edges while a column is on the output.
        stream(1'b1, 1'b0, -1, 0, 9);
        #2;
        t_vld = 1'b0;
        rst   = 1'b1;
        #1;
        chk("t6_col_vld", COLW'(o_col_vld), '0);
        chk("t6_col", o_col, '0);
        chk("t6_col_wt", o_col_wt, '0);
        chk("t6_eof", COLW'(o_eof), '0);
        exp_wt = '0;
        @(negedge clk);
        rst   = 1'b0;
        n_vld = 0;
        stream(1'b0, 1'b0, -1, 0, 16);
        chk("t6_count", COLW'(n_vld), COLW'(8));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
